surf_cout_dout_tx: RTL and testbench
====================================

Name: surf_cout_dout_tx

Overview:
SURF-side transmit framer for the COUT/DOUT link; it is the far-end counterpart of the TURFIO capture PHY.
- Serializes 32-bit command-response words onto COUT as 4-bit nybbles, one word per 8-cycle sync frame.
- Serializes 8-bit data bytes onto DOUT as 4-bit nybbles, one byte per 2-cycle slot.
- Parallel nybbles feed the existing OSERDES 4:1 DDR wrapper, which is outside this block.
- Provides a training mode with fixed patterns so the receiver can run IDELAY and bitslip alignment.

Parameters:
- TRAIN_COUT, 32'hA55A6996, COUT word sent every frame while training.
- TRAIN_DOUT, 8'hB8, DOUT byte sent every slot while training.
- IDLE_COUT, 32'h00000000, COUT word sent when no command is available.
- IDLE_DOUT, 8'h00, DOUT byte sent on underrun.

Ports:
- sysclk_i  in  1  system clock; the only clock.
- rst_i  in  1  asynchronous, active-high reset.
- sync_i  in  1  one-cycle pulse every 8 sysclk_i cycles; marks the frame boundary.
- train_i  in  1  1 = send training patterns on both lanes.
- cmd_tdata  in  32  COUT word.
- cmd_tvalid  in  1  COUT word valid.
- cmd_tready  out  1  COUT word accepted this cycle.
- dat_tdata  in  8  DOUT byte.
- dat_tvalid  in  1  DOUT byte valid.
- dat_tready  out  1  DOUT byte accepted this cycle.
- cout_o  out  4  COUT nybble to OSERDES; bit3 is transmitted first.
- dout_o  out  4  DOUT nybble to OSERDES; bit3 is transmitted first.
- locked_o  out  1  frame phase established.
- sync_err_o  out  8  saturating count of misplaced sync_i pulses.
- underrun_o  out  8  saturating count of DOUT slots filled with IDLE_DOUT while locked and not training.

Behaviour:
Reset values:
- All outputs are 0; locked_o = 0.
- Both shift registers are 0; frame counter fcnt = 0.
- cmd_tready and dat_tready are 0 while rst_i is high.

Frame phase:
- fcnt is 3 bits and increments every cycle.
- sync_i forces fcnt to 0 on the next cycle.
- First sync_i after reset: locked_o <= 1 on the next cycle.
- sync_i while locked with fcnt != 7: count sync_err_o (saturating at 255), realign to the new phase, and abort the in-flight word; its remaining nybbles are dropped.

Load strobe:
- ld = sync_i | (locked_o & fcnt==7).

COUT lane:
- cmd_tready = ld & locked_o & ~train_i. On the very first sync, locked_o is still 0, so the idle word is loaded.
- On ld, the 32-bit shift register loads, in priority order:
  - train_i: TRAIN_COUT
  - cmd_tvalid & cmd_tready: cmd_tdata
  - otherwise: IDLE_COUT
- Otherwise the register shifts left by 4 bits.
- cout_o is registered and presents bits [31:28] of the loaded word the cycle after ld, then [27:24], and so on.
- Word latency: ld to first nybble is 1 cycle; ld to last nybble is 8 cycles.

DOUT lane:
- Slot phase is fcnt[0]; a byte loads when fcnt[0]==1 or when ld occurs.
- dat_tready = that load condition & locked_o & ~train_i.
- Load priority is the same as COUT: TRAIN_DOUT, then dat_tdata, then IDLE_DOUT.
- An IDLE_DOUT load while locked and not training increments underrun_o (saturating at 255).
- Nybble order is low nybble [3:0] first, then high nybble [7:4]. This matches the receiver, which stores {current, previous}.
- 4 bytes per frame.

Mode changes:
- A train_i change takes effect only at the next load on each lane; a word or byte already in flight completes unchanged.
- train_i overrides tvalid; no handshake occurs while training.

Before lock:
- Both lanes send 0.
- No tready is asserted except on the initial sync (rule above).

Reset mid-frame:
- Immediate return to reset values; lock is lost until the next sync_i.

Optional Feature:
Macro: SURF_TX_PRBS_EN
- Defined:
  - In training, DOUT bytes come from a PRBS-7 generator (x^7+x^6+1, seed 7'h7F, advances 8 bits per byte load) instead of TRAIN_DOUT.
  - The generator reseeds when train_i rises.
  - COUT training is unchanged.
- Undefined: no generator logic; DOUT training sends TRAIN_DOUT.

Decomposition:
- Package surf_cout_dout_tx_pkg holds:
  - the default TRAIN_/IDLE_ constants
  - the frame length (8) and slot length (2)
  - the nybble width (4)
  - the PRBS polynomial and seed
- One sub-module, surf_tx_nyb_shreg, is instantiated once per lane:
  - parameterized load width
  - load/shift controls
  - MSB-first or LSB-nybble-first order selected by parameter
  - registered nybble output

Test Plan:
1. Reset, then sync_i at cycles 10, 18, 26 with cmd 32'h12345678 valid -> cmd_tready=0 at cycle 10 and 1 at cycle 18. cout_o reads 0 over cycles 11-18, then 1,2,3,4,5,6,7,8 over cycles 19-26. locked_o=1 from cycle 11.
2. Locked, train_i=1 -> cout_o cycles A,5,5,A,6,9,9,6 per frame and dout_o alternates 8,B. No tready asserted. underrun_o is unchanged.
3. Locked, dat bytes 8'h3C, 8'hF0 back-to-back -> dout_o sequence C,3,0,F. With dat_tvalid=0 afterwards, dout_o=0 and underrun_o increments once per slot.
4. Locked, extra sync_i at fcnt=3 -> sync_err_o=1, remainder of the in-flight word dropped, next word's [31:28] nybble 1 cycle after the extra pulse. 300 misplaced syncs -> sync_err_o=255.
5. rst_i asserted mid-frame at fcnt=4 -> outputs and counters read 0 in the same cycle, locked_o=0, no tready until the next sync_i.
6. With SURF_TX_PRBS_EN defined, train_i rises -> first DOUT byte is the PRBS-7 output from seed 7'h7F (checked against bench model), and the sequence repeats every 127 bytes.

Source files
------------

// File: rtl/surf_cout_dout_tx_pkg.sv
// surf_cout_dout_tx_pkg
//   Shared constants and types for the SURF COUT/DOUT transmit framer:
//   default training/idle patterns, frame and slot geometry, nybble width,
//   the PRBS-7 definition and a one-byte PRBS stepping helper.
//   Optional feature macro used by the framer: SURF_TX_PRBS_EN.
package surf_cout_dout_tx_pkg;

    localparam logic [31:0] TRAIN_COUT_DEF = 32'hA55A6996;
    localparam logic [7:0]  TRAIN_DOUT_DEF = 8'hB8;
    localparam logic [31:0] IDLE_COUT_DEF  = 32'h00000000;
    localparam logic [7:0]  IDLE_DOUT_DEF  = 8'h00;

    localparam int FRAME_LEN = 8;
    localparam int SLOT_LEN  = 2;
    localparam int NYB_W     = 4;
    localparam int FCNT_W    = $clog2(FRAME_LEN);
    localparam int SLOT_W    = $clog2(SLOT_LEN);

    // x^7 + x^6 + 1: feedback is state[6] ^ state[5]
    localparam logic [6:0] PRBS_TAPS = 7'b110_0000;
    localparam logic [6:0] PRBS_SEED = 7'h7F;

    typedef enum logic {ORDER_MSB_FIRST, ORDER_LSB_FIRST} nyb_order_e;

    typedef struct packed {
        logic [6:0] state;
        logic [7:0] data;
    } prbs_step_t;

    // Advance the generator 8 bits; the first generated bit lands in data[7].
    function automatic prbs_step_t prbs7_byte(input logic [6:0] s);
        prbs_step_t r;
        logic       nb;
        r.state = s;
        r.data  = '0;
        for (int i = 0; i < 8; i++) begin
            nb      = ^(r.state & PRBS_TAPS);
            r.state = {r.state[5:0], nb};
            r.data  = {r.data[6:0], nb};
        end
        return r;
    endfunction

endpackage

// File: rtl/surf_tx_nyb_shreg.sv
// surf_tx_nyb_shreg
//   Load-or-shift register that emits one registered nybble per cycle.
//   On ld_i the new word's first nybble goes straight to nyb_o on the next
//   cycle; otherwise the remaining content keeps draining. ORDER picks
//   MSB-nybble-first or LSB-nybble-first.
//   Ports: clk_i, rst_i (async, active high), ld_i, data_i[LOAD_W], nyb_o[4].
module surf_tx_nyb_shreg
    import surf_cout_dout_tx_pkg::*;
#(
    parameter int         LOAD_W = 32,
    parameter nyb_order_e ORDER  = ORDER_MSB_FIRST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_i,
    input  logic [LOAD_W-1:0] data_i,
    output logic [NYB_W-1:0]  nyb_o
);

    logic [LOAD_W-1:0] sreg_q, sreg_d, src;
    logic [NYB_W-1:0]  nyb_q, nyb_d;

    always_comb begin
        src = ld_i ? data_i : sreg_q;
        if (ORDER == ORDER_MSB_FIRST) begin
            nyb_d  = src[LOAD_W-1 -: NYB_W];
            sreg_d = src << NYB_W;
        end else begin
            nyb_d  = src[NYB_W-1:0];
            sreg_d = src >> NYB_W;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q <= '0;
            nyb_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            nyb_q  <= nyb_d;
        end
    end

    assign nyb_o = nyb_q;

endmodule

// File: rtl/surf_cout_dout_tx.sv
// surf_cout_dout_tx
//   SURF-side COUT/DOUT transmit framer. One 32-bit command word per 8-cycle
//   frame on COUT (MSB nybble first), one byte per 2-cycle slot on DOUT (low
//   nybble first), plus fixed training patterns for receiver alignment.
//   Ports: sysclk_i, rst_i (async, active high), sync_i, train_i,
//          cmd_* / dat_* AXI-stream style inputs with tready outputs,
//          cout_o/dout_o nybbles to OSERDES, locked_o, sync_err_o, underrun_o.
//   Optional: SURF_TX_PRBS_EN replaces the DOUT training byte with PRBS-7.
module surf_cout_dout_tx
    import surf_cout_dout_tx_pkg::*;
#(
    parameter logic [31:0] TRAIN_COUT = TRAIN_COUT_DEF,
    parameter logic [7:0]  TRAIN_DOUT = TRAIN_DOUT_DEF,
    parameter logic [31:0] IDLE_COUT  = IDLE_COUT_DEF,
    parameter logic [7:0]  IDLE_DOUT  = IDLE_DOUT_DEF
) (
    input  logic             sysclk_i,
    input  logic             rst_i,
    input  logic             sync_i,
    input  logic             train_i,
    input  logic [31:0]      cmd_tdata,
    input  logic             cmd_tvalid,
    output logic             cmd_tready,
    input  logic [7:0]       dat_tdata,
    input  logic             dat_tvalid,
    output logic             dat_tready,
    output logic [NYB_W-1:0] cout_o,
    output logic [NYB_W-1:0] dout_o,
    output logic             locked_o,
    output logic [7:0]       sync_err_o,
    output logic [7:0]       underrun_o
);

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              locked_q, locked_d;
    logic [7:0]        sync_err_q, sync_err_d;
    logic [7:0]        underrun_q, underrun_d;
    logic              frame_end, ld, dat_ld, sync_bad, und_inc;
    logic [31:0]       cout_word;
    logic [7:0]        dout_word, train_dout;

    assign frame_end = (fcnt_q == FCNT_W'(FRAME_LEN - 1));
    assign ld        = sync_i | (locked_q & frame_end);
    // Last cycle of each 2-cycle slot, or any frame load (a realigning sync
    // restarts the slot phase too).
    assign dat_ld    = ld | (&fcnt_q[SLOT_W-1:0]);

    // locked_q is cleared by reset, so both readies are low while rst_i is high.
    assign cmd_tready = ld & locked_q & ~train_i;
    assign dat_tready = dat_ld & locked_q & ~train_i;

    assign sync_bad = sync_i & locked_q & ~frame_end;
    assign und_inc  = dat_ld & locked_q & ~train_i & ~dat_tvalid;

`ifdef SURF_TX_PRBS_EN
    logic       train_q;
    logic [6:0] prbs_q, prbs_d, prbs_cur;
    prbs_step_t prbs_nx;

    // A rising train_i restarts from the seed so the receiver sees a known
    // sequence start at the first training byte.
    always_comb begin
        prbs_cur   = (train_i & ~train_q) ? PRBS_SEED : prbs_q;
        prbs_nx    = prbs7_byte(prbs_cur);
        train_dout = prbs_nx.data;
        prbs_d     = prbs_cur;
        if (dat_ld & locked_q & train_i)
            prbs_d = prbs_nx.state;
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            train_q <= 1'b0;
            prbs_q  <= PRBS_SEED;
        end else begin
            train_q <= train_i;
            prbs_q  <= prbs_d;
        end
    end
`else
    assign train_dout = TRAIN_DOUT;
`endif

    // Load word selection; only sampled by the lanes on their load strobes.
    // Before lock both lanes load idle patterns.
    always_comb begin
        cout_word = IDLE_COUT;
        dout_word = IDLE_DOUT;
        if (locked_q) begin
            if (train_i) begin
                cout_word = TRAIN_COUT;
                dout_word = train_dout;
            end else begin
                if (cmd_tvalid) cout_word = cmd_tdata;
                if (dat_tvalid) dout_word = dat_tdata;
            end
        end
    end

    always_comb begin
        fcnt_d     = sync_i ? '0 : fcnt_q + 1'b1;
        locked_d   = locked_q | sync_i;
        sync_err_d = sync_err_q;
        underrun_d = underrun_q;
        if (sync_bad && sync_err_q != 8'hFF) sync_err_d = sync_err_q + 8'd1;
        if (und_inc && underrun_q != 8'hFF)  underrun_d = underrun_q + 8'd1;
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            fcnt_q     <= '0;
            locked_q   <= 1'b0;
            sync_err_q <= '0;
            underrun_q <= '0;
        end else begin
            fcnt_q     <= fcnt_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
            underrun_q <= underrun_d;
        end
    end

    // A misplaced sync raises ld, so reloading here drops the rest of the
    // in-flight word without extra logic.
    surf_tx_nyb_shreg #(.LOAD_W(32), .ORDER(ORDER_MSB_FIRST)) u_cout (
        .clk_i (sysclk_i),
        .rst_i (rst_i),
        .ld_i  (ld),
        .data_i(cout_word),
        .nyb_o (cout_o)
    );

    surf_tx_nyb_shreg #(.LOAD_W(8), .ORDER(ORDER_LSB_FIRST)) u_dout (
        .clk_i (sysclk_i),
        .rst_i (rst_i),
        .ld_i  (dat_ld),
        .data_i(dout_word),
        .nyb_o (dout_o)
    );

    assign locked_o   = locked_q;
    assign sync_err_o = sync_err_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_surf_cout_dout_tx.sv
// tb_surf_cout_dout_tx
//   Directed bench for surf_cout_dout_tx. Cycle c starts 1 ns after a rising
//   edge; inputs are driven then, outputs sampled 1 ns later.
//   With SURF_TX_PRBS_EN defined, the PRBS training sequence is also checked.
module tb_surf_cout_dout_tx;

    logic        sysclk_i = 1'b0;
    logic        rst_i, sync_i, train_i;
    logic [31:0] cmd_tdata;
    logic        cmd_tvalid, cmd_tready;
    logic [7:0]  dat_tdata;
    logic        dat_tvalid, dat_tready;
    logic [3:0]  cout_o, dout_o;
    logic        locked_o;
    logic [7:0]  sync_err_o, underrun_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] tw = 32'hA55A6996;
    logic [15:0] dw = 16'hC30F;
    logic [31:0] cw1 = 32'hCAFEF00D;
    logic [31:0] cw2 = 32'h9ABCDEF0;

    always #5 sysclk_i = ~sysclk_i;

    surf_cout_dout_tx dut (
        .sysclk_i  (sysclk_i),
        .rst_i     (rst_i),
        .sync_i    (sync_i),
        .train_i   (train_i),
        .cmd_tdata (cmd_tdata),
        .cmd_tvalid(cmd_tvalid),
        .cmd_tready(cmd_tready),
        .dat_tdata (dat_tdata),
        .dat_tvalid(dat_tvalid),
        .dat_tready(dat_tready),
        .cout_o    (cout_o),
        .dout_o    (dout_o),
        .locked_o  (locked_o),
        .sync_err_o(sync_err_o),
        .underrun_o(underrun_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cout"}, cout_o, 0);
        chk({tag, "_dout"}, dout_o, 0);
        chk({tag, "_locked"}, locked_o, 0);
        chk({tag, "_syncerr"}, sync_err_o, 0);
        chk({tag, "_underrun"}, underrun_o, 0);
        chk({tag, "_cmdrdy"}, cmd_tready, 0);
        chk({tag, "_datrdy"}, dat_tready, 0);
    endtask

`ifdef SURF_TX_PRBS_EN
    logic [7:0] pm [127];
    logic [6:0] ps;
    logic [3:0] lo;
`endif

    initial begin
        rst_i = 1'b1; train_i = 1'b0;
        sync_i = 1'b1; cmd_tvalid = 1'b1; cmd_tdata = 32'h12345678;
        dat_tvalid = 1'b1; dat_tdata = 8'h5A;
        repeat (3) @(posedge sysclk_i);
        #1;
        chk_all_zero("rst");
        rst_i = 1'b0; sync_i = 1'b0;

        // Lock, first command, training, data bytes, misplaced sync
        for (int c = 0; c <= 70; c++) begin
            sync_i     = (c >= 10 && c <= 58 && c % 8 == 2) || c == 62 || c == 70;
            train_i    = (c >= 27 && c <= 42);
            cmd_tvalid = (c <= 42) || (c >= 51 && c <= 62);
            cmd_tdata  = (c <= 42) ? 32'h12345678 : ((c <= 58) ? cw1 : cw2);
            dat_tvalid = (c >= 27 && c <= 46);
            dat_tdata  = (c <= 42) ? 8'h55 : ((c <= 44) ? 8'h3C : 8'hF0);
            #1;
            if (c == 5 || c == 10) chk("prelock_cmdrdy", cmd_tready, 0);
            if (c == 10) chk("prelock_locked", locked_o, 0);
            if (c == 11) chk("lock", locked_o, 1);
            if (c >= 11 && c <= 18) chk("idle_cout", cout_o, 0);
            if (c >= 11 && c <= 18) chk("idle_dout", dout_o, 0);
            if (c == 18) chk("first_cmdrdy", cmd_tready, 1);
            if (c >= 19 && c <= 26) chk("cmd_cout", cout_o, 32'(c - 18));
            if (c >= 27 && c <= 42) begin
                chk("train_cmdrdy", cmd_tready, 0);
                chk("train_datrdy", dat_tready, 0);
            end
            if (c >= 35 && c <= 42) begin
                chk("train_cout", cout_o, tw[31-4*(c-35) -: 4]);
                chk("train_dout", dout_o, ((c - 35) % 2) ? 4'hB : 4'h8);
            end
            if (c == 43) begin
                chk("train_underrun", underrun_o, 8);
                chk("inflight_train", cout_o, 4'hA);
            end
            if (c == 44 || c == 46) chk("dat_rdy", dat_tready, 1);
            if (c == 45) chk("dat_rdy_gap", dat_tready, 0);
            if (c >= 45 && c <= 48) chk("dat_dout", dout_o, dw[15-4*(c-45) -: 4]);
            if (c == 49 || c == 50) chk("underrun_dout", dout_o, 0);
            if (c == 49) chk("underrun1", underrun_o, 9);
            if (c == 51) chk("underrun2", underrun_o, 10);
            if (c == 53) chk("underrun3", underrun_o, 11);
            if (c == 58) chk("cmd2_rdy", cmd_tready, 1);
            if (c >= 59 && c <= 62) chk("cmd2_cout", cout_o, cw1[31-4*(c-59) -: 4]);
            if (c == 62) begin
                chk("resync_rdy", cmd_tready, 1);
                chk("syncerr0", sync_err_o, 0);
            end
            if (c == 63) chk("syncerr1", sync_err_o, 1);
            if (c >= 63 && c <= 70) chk("resync_cout", cout_o, cw2[31-4*(c-63) -: 4]);
            nxt();
        end
        sync_i = 1'b0; cmd_tvalid = 1'b0; dat_tvalid = 1'b0;
        #1;
        chk("syncerr_natural", sync_err_o, 1);
        chk("still_locked", locked_o, 1);

        // Misplaced syncs every other cycle until the counter saturates
        for (int k = 0; k < 300; k++) begin
            sync_i = 1'b1;
            nxt();
            sync_i = 1'b0;
            #1;
            chk("syncerr_sat", sync_err_o, (k + 2 > 255) ? 255 : k + 2);
            nxt();
        end

        // Reset in the middle of a frame
        cmd_tdata = 32'hFFFFFFFF; cmd_tvalid = 1'b1;
        dat_tdata = 8'hFF; dat_tvalid = 1'b1;
        sync_i = 1'b1;
        nxt();
        sync_i = 1'b0;
        repeat (4) nxt();
        chk("pre_rst_cout", cout_o, 4'hF);
        rst_i = 1'b1;
        #1;
        chk_all_zero("midrst");
        sync_i = 1'b1;
        #1;
        chk("midrst_sync_cmdrdy", cmd_tready, 0);
        chk("midrst_sync_datrdy", dat_tready, 0);
        sync_i = 1'b0;
        nxt();
        rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("postrst_locked", locked_o, 0);
            chk("postrst_cmdrdy", cmd_tready, 0);
            chk("postrst_datrdy", dat_tready, 0);
            chk("postrst_cout", cout_o, 0);
            chk("postrst_dout", dout_o, 0);
            nxt();
        end
        sync_i = 1'b1;
        #1;
        chk("relock_cmdrdy", cmd_tready, 0);
        nxt();
        sync_i = 1'b0;
        chk("relock", locked_o, 1);

`ifdef SURF_TX_PRBS_EN
        // Reference PRBS-7: feedback s[6]^s[5], first bit of each byte is its MSB
        ps = 7'h7F;
        for (int b = 0; b < 127; b++) begin
            pm[b] = 8'h00;
            for (int i = 0; i < 8; i++) begin
                pm[b] = {pm[b][6:0], ps[6] ^ ps[5]};
                ps    = {ps[5:0], ps[6] ^ ps[5]};
            end
        end
        train_i = 1'b1;      // frame phase 0: no DOUT load this cycle
        nxt();               // phase 1: first training byte loads
        nxt();
        for (int b = 0; b < 254; b++) begin
            lo = dout_o;
            nxt();
            chk("prbs_byte", {dout_o, lo}, pm[b % 127]);
            nxt();
        end
        train_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
